arinc708_rx_fifo_ctrl: RTL and testbench
========================================

# arinc708_rx_fifo_ctrl

Parametrised receive-side buffer controller for ARINC 708 weather-radar data channels. Accepts decoded words from an ARINC 708 receive decoder and stores them in a circular FIFO of configurable depth. Checks packet length against a configurable word count and raises masked interrupts for packet complete, watermark, word error, length error and overflow. Sits between the decoder and the Avalon-MM register/buffer slave, replacing fixed-depth, drop-on-full receive buffering.

## Interface
- DATA_W, 32: received word width.
- DEPTH_LOG2, 9: FIFO depth = 2**DEPTH_LOG2 words.
- PKT_WORDS, 50: expected data words per packet.
- CNT_W, 8: width of packet word counter; must hold PKT_WORDS+1.

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_en  in  1  channel enable; low flushes FIFO and counters.
- rx_valid  in  1  one-cycle strobe: decoder word available.
- rx_data  in  DATA_W  decoded word, qualified by rx_valid.
- rx_err  in  1  parity/framing error on the word, qualified by rx_valid.
- rx_pkt_end  in  1  one-cycle strobe: decoder detected end of packet.
- rd_pop  in  1  read request from bus side, one word per asserted cycle.
- rd_data  out  DATA_W  read word, valid when rd_valid.
- rd_valid  out  1  one-cycle strobe, one cycle after an accepted rd_pop.
- level  out  DEPTH_LOG2+1  words currently stored (0..2**DEPTH_LOG2).
- pkt_words  out  CNT_W  good words received in current packet.
- watermark  in  DEPTH_LOG2+1  level threshold for flag bit1.
- irq_mask  in  5  per-flag interrupt enable.
- irq_clear  in  5  write-one-to-clear strobe per flag.
- irq_flags  out  5  sticky flags: [0] pkt_ok, [1] watermark, [2] word_err, [3] len_err, [4] overflow.
- irq  out  1  |(irq_flags & irq_mask), combinational.

## Operation
- Storage: simple dual-port RAM, 2**DEPTH_LOG2 x DATA_W. Write pointer wr_ptr, read pointer rd_ptr, each DEPTH_LOG2 bits, wrapping modulo depth. level is a separate DEPTH_LOG2+1 counter.
- Push: rx_valid & !rx_err & rx_en.
  - If level < depth: write rx_data at wr_ptr, wr_ptr+1, pkt_words+1 (saturate at all-ones).
  - If level == depth: word dropped, pointers unchanged, set flag[4]. pkt_words still increments; the packet was received, only storage failed.
- Error word: rx_valid & rx_err sets flag[2]. Not stored, not counted.
- Pop: rd_pop & level != 0 & rx_en. RAM read at rd_ptr, rd_ptr+1, rd_valid next cycle. rd_pop with level == 0 is ignored: no rd_valid, no pointer change.
- Level update: +1 on accepted push only, -1 on accepted pop only, unchanged on both or neither.
- Packet end: on rx_pkt_end, pkt_words == PKT_WORDS sets flag[0]; otherwise sets flag[3]. pkt_words is then cleared to 0. If rx_valid coincides, that word counts toward the ending packet.
- Watermark: flag[1] set on the cycle level transitions from < watermark to >= watermark. watermark == 0 never sets it.
- Flags are sticky. irq_clear[i] clears bit i. Set and clear in the same cycle: set wins.
- rx_en low: wr_ptr, rd_ptr, level, pkt_words forced to 0 each cycle. Pushes, pops and rx_pkt_end ignored. rd_valid forced 0. irq_flags retained; irq_clear still works.
- Reset: all pointers, level, pkt_words, irq_flags, rd_valid cleared to 0. rd_data resets to 0. RAM contents undefined.

## Timing
- Write latency: pushed word readable by rd_pop one cycle after the push cycle (level reflects it then).
- Read latency: rd_data/rd_valid exactly 1 cycle after the rd_pop cycle. Back-to-back pops give one word per cycle.
- Flag latency: flags register one cycle after the causing event. irq follows flags combinationally.
- Full with simultaneous push and pop: pop accepted, push accepted (pop frees the slot in the same cycle), level stays at depth, no overflow.
- Empty with simultaneous push and pop: pop ignored, push accepted, level 0->1.
- Pointer wrap: wr_ptr/rd_ptr roll from depth-1 to 0 without disturbing level.
- Reset asserted mid-packet or mid-read: outputs cleared asynchronously. First push after reset release lands at address 0.

## Test plan
- Nominal packet: 50 good words then rx_pkt_end, reset released, rx_en=1 -> level=50, pkt_words back to 0, flag[0]=1, irq=1 with mask=5'b00001. Pop 50 -> data in order, level=0.
- Short packet / error word: 49 good words + 1 with rx_err, then rx_pkt_end -> flag[2]=1, flag[3]=1, flag[0]=0, level=49.
- Overflow (DEPTH_LOG2=4): 17 pushes with no pops -> level=16, flag[4]=1, 17th word absent. Then push+pop same cycle at full -> level stays 16, no new overflow.
- Wrap and watermark: depth 16, watermark=8. Push 12, pop 10, push 12 -> flag[1] set once on 7->8, data order preserved across wrap, level=14.
- Clear priority: flag[0] set event and irq_clear[0] in the same cycle -> flag[0] remains 1. Clear alone next cycle -> 0, irq deasserts.
- Flush/reset: rx_en low with level=20 -> level=0 next cycle, flags kept. reset pulse mid-read -> rd_valid=0, level=0 immediately.

Source files
------------

// File: rtl/arinc708_rx_fifo_ctrl.sv
// Receive-side circular buffer for an ARINC 708 channel: stores good decoder words,
// tracks packet length and raises sticky, maskable interrupt flags.
module arinc708_rx_fifo_ctrl #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 9,
  parameter int PKT_WORDS  = 50,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_en,
  input  logic                  rx_valid,
  input  logic [DATA_W-1:0]     rx_data,
  input  logic                  rx_err,
  input  logic                  rx_pkt_end,
  input  logic                  rd_pop,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   level,
  output logic [CNT_W-1:0]      pkt_words,
  input  logic [DEPTH_LOG2:0]   watermark,
  input  logic [4:0]            irq_mask,
  input  logic [4:0]            irq_clear,
  output logic [4:0]            irq_flags,
  output logic                  irq
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [CNT_W-1:0]    PKT_CNT  = CNT_W'(PKT_WORDS);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [CNT_W-1:0]      pkt_words_q, pkt_words_d;
  logic [4:0]            flags_q, flags_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]     rd_data_q;

  logic             push_req, push_acc, pop_acc, full, ovf, pkt_end, pkt_ok, wm_hit;
  logic [CNT_W-1:0] pkt_inc;
  logic [4:0]       flag_set;

  always_comb begin
    push_req = rx_en & rx_valid & ~rx_err;
    pop_acc  = rx_en & rd_pop & (level_q != '0);
    full     = (level_q == FULL_LVL);
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    push_acc = push_req & (~full | pop_acc);
    ovf      = push_req & full & ~pop_acc;
    pkt_end  = rx_en & rx_pkt_end;
    pkt_inc  = (push_req && (pkt_words_q != '1)) ? pkt_words_q + 1'b1 : pkt_words_q;
    pkt_ok   = pkt_end & (pkt_inc == PKT_CNT);

    wr_ptr_d    = push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop_acc  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d     = level_q;
    if (push_acc && !pop_acc) begin
      level_d = level_q + 1'b1;
    end else if (pop_acc && !push_acc) begin
      level_d = level_q - 1'b1;
    end
    pkt_words_d = pkt_end ? '0 : pkt_inc;
    rd_valid_d  = pop_acc;

    if (!rx_en) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      pkt_words_d = '0;
      rd_valid_d  = 1'b0;
    end

    wm_hit   = (watermark != '0) && (level_q < watermark) && (level_d >= watermark);
    flag_set = {ovf, pkt_end & ~pkt_ok, rx_valid & rx_err, wm_hit, pkt_ok};
    flags_d  = (flags_q & ~irq_clear) | flag_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pkt_words_q <= '0;
      flags_q     <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pkt_words_q <= pkt_words_d;
      flags_q     <= flags_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // Read-before-write: a push+pop at full on the same address returns the old word.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr_q] <= rx_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (pop_acc) begin
      rd_data_q <= mem[rd_ptr_q];
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign level     = level_q;
  assign pkt_words = pkt_words_q;
  assign irq_flags = flags_q;
  assign irq       = |(flags_q & irq_mask);

endmodule

// File: tb/tb_arinc708_rx_fifo_ctrl.sv
// Directed bench for arinc708_rx_fifo_ctrl with a 16-word FIFO and 12-word packets.
module tb_arinc708_rx_fifo_ctrl;

  localparam int DATA_W = 32;
  localparam int DL2    = 4;
  localparam int PKTW   = 12;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_en, rx_valid, rx_err, rx_pkt_end, rd_pop;
  logic [DATA_W-1:0] rx_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [DL2:0]      level;
  logic [CNT_W-1:0]  pkt_words;
  logic [DL2:0]      watermark;
  logic [4:0]        irq_mask, irq_clear, irq_flags;
  logic              irq;

  int checks = 0;
  int errors = 0;

  arinc708_rx_fifo_ctrl #(
    .DATA_W(DATA_W), .DEPTH_LOG2(DL2), .PKT_WORDS(PKTW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .rx_en(rx_en), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_err(rx_err), .rx_pkt_end(rx_pkt_end), .rd_pop(rd_pop), .rd_data(rd_data),
    .rd_valid(rd_valid), .level(level), .pkt_words(pkt_words), .watermark(watermark),
    .irq_mask(irq_mask), .irq_clear(irq_clear), .irq_flags(irq_flags), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] w);
    rx_valid = 1'b1; rx_err = 1'b0; rx_data = w;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pop_chk(input logic [DATA_W-1:0] w);
    rd_pop = 1'b1;
    tick();
    rd_pop = 1'b0;
    chk("pop_valid", rd_valid, 1);
    chk("pop_data", rd_data, w);
  endtask

  task automatic clear_all();
    irq_clear = 5'h1F;
    tick();
    irq_clear = 5'h00;
  endtask

  task automatic flush();
    rx_en = 1'b0;
    tick();
    rx_en = 1'b1;
  endtask

  initial begin
    reset = 1'b1; rx_en = 1'b0; rx_valid = 1'b0; rx_err = 1'b0; rx_pkt_end = 1'b0;
    rd_pop = 1'b0; rx_data = '0; watermark = '0; irq_mask = 5'b00001; irq_clear = '0;
    #3;
    chk("rst_level", level, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_flags", irq_flags, 0);
    chk("rst_pkt_words", pkt_words, 0);
    chk("rst_irq", irq, 0);
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;
    rx_en = 1'b1;
    tick();

    // Nominal packet
    for (int i = 0; i < PKTW; i++) push(32'hA000 + i);
    chk("nom_pkt_words", pkt_words, 12);
    rx_pkt_end = 1'b1; tick(); rx_pkt_end = 1'b0;
    chk("nom_flags", irq_flags, 5'b00001);
    chk("nom_pkt_clr", pkt_words, 0);
    chk("nom_level", level, 12);
    chk("nom_irq", irq, 1);
    for (int i = 0; i < PKTW; i++) pop_chk(32'hA000 + i);
    chk("nom_level_end", level, 0);
    rd_pop = 1'b1; tick(); rd_pop = 1'b0;
    chk("empty_pop_valid", rd_valid, 0);
    chk("empty_pop_level", level, 0);
    clear_all();
    chk("clr_flags", irq_flags, 0);

    // Short packet with an error word
    for (int i = 0; i < PKTW - 1; i++) push(32'h5000 + i);
    rx_valid = 1'b1; rx_err = 1'b1; rx_data = 32'hDEAD; tick(); rx_valid = 1'b0; rx_err = 1'b0;
    chk("err_flags", irq_flags, 5'b00100);
    chk("err_pkt_words", pkt_words, 11);
    rx_pkt_end = 1'b1; tick(); rx_pkt_end = 1'b0;
    chk("short_flags", irq_flags, 5'b01100);
    chk("short_level", level, 11);
    chk("short_irq", irq, 0);

    // Flush keeps flags; pushes ignored while disabled
    rx_en = 1'b0; tick();
    chk("flush_level", level, 0);
    chk("flush_flags", irq_flags, 5'b01100);
    rx_valid = 1'b1; rx_data = 32'h1111; tick(); rx_valid = 1'b0;
    chk("dis_push_level", level, 0);
    rx_en = 1'b1;
    clear_all();

    // Last word coincides with packet end; clear on same cycle loses to set
    for (int i = 0; i < PKTW - 1; i++) push(32'h6000 + i);
    rx_valid = 1'b1; rx_data = 32'h600B; rx_pkt_end = 1'b1; irq_clear = 5'b00001;
    tick();
    rx_valid = 1'b0; rx_pkt_end = 1'b0; irq_clear = 5'b00000;
    chk("prio_flags", irq_flags, 5'b00001);
    chk("prio_level", level, 12);
    chk("prio_irq", irq, 1);
    irq_clear = 5'b00001; tick(); irq_clear = 5'b00000;
    chk("clr_alone_flags", irq_flags, 0);
    chk("clr_alone_irq", irq, 0);
    flush();

    // Overflow
    for (int i = 0; i < 17; i++) push(32'hB000 + i);
    chk("ovf_level", level, 16);
    chk("ovf_flags", irq_flags, 5'b10000);
    chk("ovf_pkt_words", pkt_words, 17);
    clear_all();
    rx_valid = 1'b1; rx_data = 32'hB0FF; rd_pop = 1'b1;
    tick();
    rx_valid = 1'b0; rd_pop = 1'b0;
    chk("full_pp_valid", rd_valid, 1);
    chk("full_pp_data", rd_data, 32'hB000);
    chk("full_pp_level", level, 16);
    chk("full_pp_flags", irq_flags, 0);
    for (int i = 1; i < 16; i++) pop_chk(32'hB000 + i);
    pop_chk(32'hB0FF);
    chk("ovf_drain_level", level, 0);
    flush();

    // Wrap and watermark
    watermark = 5'd8;
    for (int i = 0; i < 7; i++) push(32'hC000 + i);
    chk("wm_below", irq_flags, 0);
    push(32'hC007);
    chk("wm_cross", irq_flags, 5'b00010);
    for (int i = 8; i < 12; i++) push(32'hC000 + i);
    clear_all();
    for (int i = 0; i < 10; i++) pop_chk(32'hC000 + i);
    chk("wm_pop_level", level, 2);
    chk("wm_pop_flags", irq_flags, 0);
    for (int i = 12; i < 18; i++) push(32'hC000 + i);
    chk("wm_cross2", irq_flags, 5'b00010);
    irq_clear = 5'b00010; push(32'hC012); irq_clear = 5'b00000;
    for (int i = 19; i < 24; i++) push(32'hC000 + i);
    chk("wm_once", irq_flags, 0);
    chk("wrap_level", level, 14);
    for (int i = 10; i < 24; i++) pop_chk(32'hC000 + i);
    chk("wrap_level_end", level, 0);
    watermark = '0;

    // Reset mid-read
    push(32'hE000); push(32'hE001); push(32'hE002);
    rd_pop = 1'b1; tick();
    chk("mid_valid", rd_valid, 1);
    chk("mid_data", rd_data, 32'hE000);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", rd_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_data", rd_data, 0);
    rd_pop = 1'b0;
    @(posedge clk); #2 reset = 1'b0;
    tick();
    push(32'hE100);
    chk("post_rst_level", level, 1);
    pop_chk(32'hE100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
